// File: rtl/ifm_bram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ifm_bram_loader_if
// Brief    : Byte-stream input and 16-bank BRAM write-port bundle for the
//            layer00 IFM loader.
// Revision : 1.0
// ============================================================================
interface ifm_bram_loader_if #(
    parameter int NUM_BANK = 16,
    parameter int ADDR_W   = 9,
    parameter int LEN_W    = 14
);
    logic                    iStart;
    logic [ADDR_W-1:0]       iBaseAddr;
    logic [LEN_W-1:0]        iLen;
    logic [7:0]              iData;
    logic                    iValid;
    logic                    oReady;
    logic [NUM_BANK-1:0]     o_ena;
    logic [NUM_BANK-1:0]     o_wea;
    logic [ADDR_W-1:0]       o_addra;
    logic [8*NUM_BANK-1:0]   o_dia;
    logic                    oBusy;
    logic                    oDone;

    modport master (
        output iStart, iBaseAddr, iLen, iData, iValid,
        input  oReady, o_ena, o_wea, o_addra, o_dia, oBusy, oDone
    );

    modport slave (
        input  iStart, iBaseAddr, iLen, iData, iValid,
        output oReady, o_ena, o_wea, o_addra, o_dia, oBusy, oDone
    );
endinterface
`default_nettype wire

// File: rtl/ifm_bram_loader.sv
`default_nettype none
// ============================================================================
// Module   : ifm_bram_loader
// Brief    : Packs a byte stream into 128-bit words and writes them to the
//            16-bank layer00 IFM BRAM, then pulses oDone.
// Revision : 1.0
// ============================================================================
module ifm_bram_loader #(
    parameter int NUM_BANK = 16,
    parameter int ADDR_W   = 9,
    parameter int LEN_W    = 14
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ifm_bram_loader_if.slave bus
);
    localparam int                  c_LANE_W   = $clog2(NUM_BANK);
    localparam logic [1:0]          c_S_IDLE   = 2'd0;
    localparam logic [1:0]          c_S_LOAD   = 2'd1;
    localparam logic [1:0]          c_S_FLUSH  = 2'd2;
    localparam logic [1:0]          c_S_DONE   = 2'd3;
    localparam logic [NUM_BANK-1:0] c_ALL_ONES = {NUM_BANK{1'b1}};
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(NUM_BANK - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_count;
    logic [c_LANE_W-1:0]   r_lane;
    logic [8*NUM_BANK-1:0] r_pack;
    logic [8*NUM_BANK-1:0] w_pack_next;
    logic [NUM_BANK-1:0]   w_mask;
    logic [NUM_BANK-1:0]   r_ena;
    logic [ADDR_W-1:0]     r_addra;
    logic [8*NUM_BANK-1:0] r_dia;
    logic                  r_done;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_emit;

    assign w_accept = w_ready && bus.iValid;
    assign w_last   = w_accept && ((r_count + LEN_W'(1)) == r_len);
    assign w_emit   = w_accept && (w_last || (r_lane == c_LAST_LANE));

    // Lanes fill in order, so the filled set is always a contiguous low mask.
    always_comb begin
        w_mask = c_ALL_ONES >> (c_LAST_LANE - r_lane);
    end

    for (genvar k = 0; k < NUM_BANK; k++) begin : g_lane
        assign w_pack_next[8*k +: 8] = (r_lane == c_LANE_W'(k)) ? bus.iData
                                                                : r_pack[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (bus.iStart) begin
                    w_next_state = (bus.iLen == '0) ? c_S_DONE : c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (w_last) begin
                    w_next_state = c_S_FLUSH;
                end
            end
            c_S_FLUSH: w_next_state = c_S_DONE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            c_S_LOAD:  begin w_ready = 1'b1; w_busy = 1'b1; end
            c_S_FLUSH: w_busy = 1'b1;
            c_S_DONE:  w_busy = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_lane  <= '0;
            r_pack  <= '0;
            r_ena   <= '0;
            r_addra <= '0;
            r_dia   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_ena  <= '0;
            r_done <= (w_next_state == c_S_DONE);
            if ((r_state == c_S_IDLE) && bus.iStart) begin
                r_addr  <= bus.iBaseAddr;
                r_len   <= bus.iLen;
                r_count <= '0;
                r_lane  <= '0;
                r_pack  <= '0;
            end
            if (w_accept) begin
                r_count <= r_count + LEN_W'(1);
                r_lane  <= (r_lane == c_LAST_LANE) ? '0 : r_lane + c_LANE_W'(1);
                if (w_emit) begin
                    // Unfilled lanes are already zero because the pack clears on emit.
                    r_dia   <= w_pack_next;
                    r_ena   <= w_mask;
                    r_addra <= r_addr;
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_pack  <= '0;
                end else begin
                    r_pack  <= w_pack_next;
                end
            end
        end
    end

    assign bus.oReady  = w_ready;
    assign bus.oBusy   = w_busy;
    assign bus.oDone   = r_done;
    assign bus.o_ena   = r_ena;
    assign bus.o_wea   = r_ena;
    assign bus.o_addra = r_addra;
    assign bus.o_dia   = r_dia;
endmodule
`default_nettype wire

// File: tb/tb_ifm_bram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifm_bram_loader
// Brief    : Randomised scoreboard bench for ifm_bram_loader.
// Revision : 1.0
// ============================================================================
module tb_ifm_bram_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [8:0]   addr;
        logic [15:0]  ena;
        logic [127:0] dia;
        int           cyc;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    wr_t         mon_e;
    int          mon_d;
    logic [7:0]  stim [0:255];

    ifm_bram_loader_if #(.NUM_BANK(16), .ADDR_W(9), .LEN_W(14)) bus();

    ifm_bram_loader #(.NUM_BANK(16), .ADDR_W(9), .LEN_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: every presented write and every done pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ena != 16'h0) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d ena=%h dia=%h at cyc %0d, expected no write",
                             bus.o_addra, bus.o_ena, bus.o_dia, cyc);
                end else begin
                    mon_e = exp_wr.pop_front();
                    if (bus.o_addra !== mon_e.addr || bus.o_ena !== mon_e.ena ||
                        bus.o_wea !== mon_e.ena || bus.o_dia !== mon_e.dia || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL write: got addr=%0d ena=%h wea=%h dia=%h cyc=%0d, expected addr=%0d ena=%h dia=%h cyc=%0d",
                                 bus.o_addra, bus.o_ena, bus.o_wea, bus.o_dia, cyc,
                                 mon_e.addr, mon_e.ena, mon_e.dia, mon_e.cyc);
                    end
                end
            end
            if (bus.oDone) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got oDone=1 at cyc %0d, expected none", cyc);
                end else begin
                    mon_d = exp_done.pop_front();
                    if (cyc != mon_d || bus.oBusy !== 1'b1) begin
                        errors++;
                        $display("FAIL done: got cyc=%0d busy=%0b, expected cyc=%0d busy=1",
                                 cyc, bus.oBusy, mon_d);
                    end
                end
            end
        end
    end

    // Reference model: word w holds bytes 16w..16w+15 of the load, at base+w mod 512.
    task automatic push_word(input int base, input int len, input int w, input int acc_cyc);
        wr_t e;
        int  nb;
        nb    = (len - 16*w > 16) ? 16 : len - 16*w;
        e.addr = 9'((base + w) % 512);
        e.ena  = (nb == 16) ? 16'hFFFF : 16'((32'd1 << nb) - 1);
        e.dia  = '0;
        for (int j = 0; j < nb; j++) e.dia[8*j +: 8] = stim[16*w + j];
        e.cyc  = acc_cyc + 1;
        exp_wr.push_back(e);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.o_ena !== 16'h0 || bus.o_wea !== 16'h0 || bus.o_addra !== 9'h0 ||
            bus.o_dia !== 128'h0 || bus.oDone !== 1'b0 || bus.oReady !== 1'b0 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ena=%h wea=%h addr=%0d dia=%h done=%0b ready=%0b busy=%0b, expected all zero",
                     name, bus.o_ena, bus.o_wea, bus.o_addra, bus.o_dia, bus.oDone, bus.oReady, bus.oBusy);
        end
    endtask

    // vmode: 0 continuous, 1 pattern 1,0,0, 2 random. rst_at>0 resets after that many bytes.
    task automatic do_load(input int base, input int len, input int vmode,
                           input bit busy_start, input int rst_at);
        int idx = 0;
        int it = 0;
        int guard = 0;
        int s;
        @(posedge clk); #1;
        bus.iStart    = 1'b1;
        bus.iBaseAddr = 9'(base);
        bus.iLen      = 14'(len);
        bus.iValid    = 1'b0;
        @(negedge clk);
        s = cyc;
        checks++;
        if (bus.oReady !== 1'b0 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_start: got ready=%0b busy=%0b, expected 0 0", bus.oReady, bus.oBusy);
        end
        if (len == 0) begin
            exp_done.push_back(s + 1);
            @(posedge clk); #1;
            bus.iStart = 1'b0;
        end
        while (idx < len && guard < 2000) begin
            @(posedge clk); #1;
            bus.iStart = 1'b0;
            if (busy_start && idx == 5) begin
                bus.iStart    = 1'b1;
                bus.iBaseAddr = 9'(base + 100);
                bus.iLen      = 14'(3);
            end
            if (rst_at > 0 && idx == rst_at) begin
                rst        = 1'b1;
                bus.iValid = 1'b0;
                bus.iStart = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_idle_outputs("reset_mid_load");
                checks++;
                if (exp_wr.size() != 0 || exp_done.size() != 0) begin
                    errors++;
                    $display("FAIL reset_queues: got %0d writes %0d dones pending, expected 0 0",
                             exp_wr.size(), exp_done.size());
                end
                exp_wr.delete();
                exp_done.delete();
                return;
            end
            case (vmode)
                0:       bus.iValid = 1'b1;
                1:       bus.iValid = (it % 3 == 0);
                default: bus.iValid = 1'($urandom_range(0, 1));
            endcase
            bus.iData = stim[idx];
            @(negedge clk);
            if (bus.iValid && bus.oReady) begin
                if ((idx % 16 == 15) || (idx == len - 1)) push_word(base, len, idx / 16, cyc);
                if (idx == len - 1) exp_done.push_back(cyc + 2);
                idx++;
            end
            it++;
            guard++;
        end
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        bus.iStart = 1'b0;
        if (idx < len) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got %0d bytes accepted, expected %0d", idx, len);
        end
        guard = 0;
        while (exp_done.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no oDone, expected one by cyc %0d", exp_done[0]);
            exp_done.delete();
        end
    endtask

    initial begin
        bus.iStart    = 1'b0;
        bus.iBaseAddr = '0;
        bus.iLen      = '0;
        bus.iData     = '0;
        bus.iValid    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_state");

        for (int i = 0; i < 256; i++) stim[i] = 8'(i);
        do_load(0, 32, 0, 1'b0, 0);
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        do_load(5, 20, 0, 1'b0, 0);
        do_load(511, 48, 0, 1'b0, 0);
        do_load(int'($urandom_range(0, 511)), 16, 1, 1'b0, 0);
        do_load(77, 0, 0, 1'b0, 0);
        do_load(10, 40, 2, 1'b1, 0);
        do_load(0, 32, 0, 1'b0, 10);
        do_load(3, 16, 0, 1'b0, 0);
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
            do_load(int'($urandom_range(0, 511)), int'($urandom_range(0, 100)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_wr.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes %0d dones outstanding, expected 0 0",
                     exp_wr.size(), exp_done.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
